// File: rtl/odd_result_pipe.sv
// Result staging pipe behind the SPU odd pipe: carries results to the odd
// register-file write port and exposes every stage to forwarding and RAW lookup.
module odd_result_pipe #(
  parameter int DEPTH       = 7,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 7,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  // Handshake: in_valid is a qualifier only; there is no ready. A result with
  // in_valid high is taken on the next rising edge unless reset or flush is high.
  input  logic                     in_valid,
  input  logic [0:DATA_W-1]        in_data,
  input  logic [0:ADDR_W-1]        in_addr,
  input  logic                     in_wr_en,
  input  logic [0:2]               in_latency,
  input  logic                     flush,
  input  logic [0:ADDR_W-1]        query_addr,
  output logic [0:DEPTH-1]         fwd_valid,
  output logic [0:DEPTH-1]         fwd_ready,
  output logic [0:DEPTH*ADDR_W-1]  fwd_addr,
  output logic [0:DEPTH*DATA_W-1]  fwd_data,
  output logic                     rf_wr_en,
  output logic [0:ADDR_W-1]        rf_addr,
  output logic [0:DATA_W-1]        rf_data,
  output logic                     pending_hit
);

  // Array index i holds stage i+1.
  function automatic logic [DEPTH-1:0] kill_mask_f();
    logic [DEPTH-1:0] m;
    m = '0;
    for (int i = 1; i < DEPTH; i++) begin
      m[i] = (i < FLUSH_DEPTH);
    end
    return m;
  endfunction

  localparam logic [DEPTH-1:0] KILL_MASK = kill_mask_f();

  logic              valid_q [DEPTH];
  logic              wr_en_q [DEPTH];
  logic [2:0]        lat_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];

  logic [2:0]        lat_in;
  logic [2:0]        lat_eff;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  hit;

  // Latency encodings below 2 are not meaningful for any odd unit; clamp to 2.
  assign lat_in  = in_latency;
  assign lat_eff = (lat_in < 3'd2) ? 3'd2 : lat_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        wr_en_q[i] <= 1'b0;
        lat_q[i]   <= 3'd0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid & ~flush;
      wr_en_q[0] <= in_wr_en;
      lat_q[0]   <= lat_eff;
      addr_q[0]  <= in_addr;
      data_q[0]  <= in_data;
      // Payload always shifts; only valid is gated, so older results (e.g. a
      // resolved branch-and-set-link) survive a flush.
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~(flush & KILL_MASK[i]);
        wr_en_q[i] <= wr_en_q[i-1];
        lat_q[i]   <= lat_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    localparam int unsigned STAGE = g + 1;
    // Readiness depends only on the stage position, so it is recomputed here
    // rather than carried as a sticky bit.
    assign ready[g]     = valid_q[g] && (STAGE >= 32'(lat_q[g]));
    assign fwd_valid[g] = valid_q[g] & wr_en_q[g];
    assign fwd_ready[g] = fwd_valid[g] & ready[g];
    assign fwd_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    assign fwd_data[g*DATA_W +: DATA_W] = data_q[g];
    assign hit[g] = fwd_valid[g] & ~ready[g] & (addr_q[g] == query_addr);
  end

  assign pending_hit = |hit;

  assign rf_wr_en = fwd_valid[DEPTH-1];
  assign rf_addr  = addr_q[DEPTH-1];
  assign rf_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_odd_result_pipe.sv
// Bench for odd_result_pipe: directed table and corner sequences plus random
// traffic, all checked against an edge-indexed history model.
module tb_odd_result_pipe;

  localparam int DEPTH  = 7;
  localparam int FD     = 1;
  localparam int MAXE   = 4096;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic                 in_valid;
  logic [0:127]         in_data;
  logic [0:6]           in_addr;
  logic                 in_wr_en;
  logic [0:2]           in_latency;
  logic                 flush;
  logic [0:6]           query_addr;
  logic [0:DEPTH-1]     fwd_valid;
  logic [0:DEPTH-1]     fwd_ready;
  logic [0:DEPTH*7-1]   fwd_addr;
  logic [0:DEPTH*128-1] fwd_data;
  logic                 rf_wr_en;
  logic [0:6]           rf_addr;
  logic [0:127]         rf_data;
  logic                 pending_hit;

  odd_result_pipe #(.DEPTH(DEPTH), .DATA_W(128), .ADDR_W(7), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_addr(in_addr), .in_wr_en(in_wr_en), .in_latency(in_latency),
    .flush(flush), .query_addr(query_addr), .fwd_valid(fwd_valid),
    .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rf_wr_en(rf_wr_en), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending_hit(pending_hit)
  );

  // ---------------- reference model: per-edge input history ----------------
  logic [6:0]   h_addr  [MAXE];
  logic [127:0] h_data  [MAXE];
  logic         h_wr    [MAXE];
  logic [2:0]   h_lat   [MAXE];
  logic         h_alive [MAXE];
  int           edge_n     = -1;
  int           last_reset = -1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
    end
  endtask

  // Stage k after edge e holds whatever was presented at edge e-k+1.
  task automatic compare_model();
    logic [0:DEPTH-1] ev;
    logic [0:DEPTH-1] er;
    logic             ep;
    logic [6:0]       last_a;
    logic [127:0]     last_d;
    ev = '0; er = '0; ep = 1'b0; last_a = '0; last_d = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      int           t;
      logic [6:0]   a;
      logic [127:0] d;
      t = edge_n - k + 1;
      a = '0;
      d = '0;
      if (t > last_reset) begin
        int le;
        le = (h_lat[t] < 3'd2) ? 2 : int'(h_lat[t]);
        a = h_addr[t];
        d = h_data[t];
        ev[k-1] = h_alive[t] & h_wr[t];
        er[k-1] = ev[k-1] && (k >= le);
        if (ev[k-1] && !(k >= le) && (a == query_addr)) ep = 1'b1;
      end
      check($sformatf("fwd_addr_s%0d", k), fwd_addr[(k-1)*7 +: 7], a);
      check($sformatf("fwd_data_s%0d", k), fwd_data[(k-1)*128 +: 128], d);
      last_a = a;
      last_d = d;
    end
    check("fwd_valid", fwd_valid, ev);
    check("fwd_ready", fwd_ready, er);
    check("pending_hit", pending_hit, ep);
    check("rf_wr_en", rf_wr_en, ev[DEPTH-1]);
    check("rf_addr", rf_addr, last_a);
    check("rf_data", rf_data, last_d);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [6:0] a, input logic [127:0] d,
                      input logic w, input logic [2:0] l, input logic f,
                      input logic r, input logic [6:0] q);
    in_valid = v; in_addr = a; in_data = d; in_wr_en = w;
    in_latency = l; flush = f; reset = r; query_addr = q;
    @(posedge clk);
    edge_n++;
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget: got %0d expected below %0d", edge_n, MAXE);
      $fatal(1, "history overflow");
    end
    h_addr[edge_n] = a; h_data[edge_n] = d; h_wr[edge_n] = w; h_lat[edge_n] = l;
    h_alive[edge_n] = v && !f && !r;
    if (r) last_reset = edge_n;
    else if (f) begin
      for (int t = edge_n - FD + 1; t < edge_n; t++)
        if (t >= 0) h_alive[t] = 1'b0;
    end
    @(negedge clk);
    if (edge_n > 0 || r) compare_model();
  endtask

  task automatic idle(input logic [6:0] q);
    step(1'b0, 7'd0, 128'd0, 1'b0, 3'd0, 1'b0, 1'b0, q);
  endtask

  task automatic do_reset();
    step(1'b0, 7'd0, 128'd0, 1'b0, 3'd0, 1'b0, 1'b1, 7'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic       v;
    logic [6:0] a;
    logic       w;
    logic [2:0] l;
    logic [6:0] q;
    logic       exp_pend;
    logic       exp_rdy3;
    logic       exp_rf;
  } vec_t;

  vec_t tbl [8];
  localparam logic [127:0] DATA_A = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] B1     = 128'hB1B1_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] B2     = 128'hB2B2_0000_0000_0000_0000_0000_0000_0002;

  initial begin
    in_valid = 0; in_addr = 0; in_data = 0; in_wr_en = 0; in_latency = 0;
    flush = 0; reset = 1; query_addr = 0;
    @(negedge clk);

    // Latency-4 result at edge 0; row i checks the cycle after edge i.
    tbl[0] = '{1'b1, 7'd5, 1'b1, 3'd4, 7'd5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 7'd0, 1'b0, 3'd0, 7'd5, 1'b0, 1'b0, 1'b0};

    do_reset();
    check("reset_fwd_valid", fwd_valid, '0);
    check("reset_rf_wr_en", rf_wr_en, 1'b0);
    check("reset_pending", pending_hit, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].v ? DATA_A : 128'd0, tbl[i].w, tbl[i].l,
           1'b0, 1'b0, tbl[i].q);
      check($sformatf("lat4_pend_c%0d", i+1), pending_hit, tbl[i].exp_pend);
      check($sformatf("lat4_rdy3_c%0d", i+1), fwd_ready[3], tbl[i].exp_rdy3);
      check($sformatf("lat4_rfwr_c%0d", i+1), rf_wr_en, tbl[i].exp_rf);
      if (tbl[i].exp_rf) begin
        check("lat4_rf_addr", rf_addr, 7'd5);
        check("lat4_rf_data", rf_data, DATA_A);
      end
    end

    // Store entry: never visible as a writer.
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) step(1'b1, 7'd9, 128'hDEAD, 1'b0, 3'd6, 1'b0, 1'b0, 7'd9);
      else idle(7'd9);
      check("store_fwd_valid", fwd_valid, '0);
      check("store_pending", pending_hit, 1'b0);
      check("store_rf_wr_en", rf_wr_en, 1'b0);
    end

    // Back-to-back writes to the same register.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      if (c == 1)      step(1'b1, 7'd3, B1, 1'b1, 3'd2, 1'b0, 1'b0, 7'd3);
      else if (c == 2) step(1'b1, 7'd3, B2, 1'b1, 3'd7, 1'b0, 1'b0, 7'd3);
      else             idle(7'd3);
      if (c >= 2) check($sformatf("b2b_pend_c%0d", c), pending_hit, c <= 7);
      check($sformatf("b2b_rfwr_c%0d", c), rf_wr_en, (c == 7) || (c == 8));
      if (c == 7) check("b2b_rf_data_1", rf_data, B1);
      if (c == 8) check("b2b_rf_data_2", rf_data, B2);
    end

    // Flush together with the third input.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      if (c == 1)      step(1'b1, 7'd1, 128'h11, 1'b1, 3'd3, 1'b0, 1'b0, 7'd3);
      else if (c == 2) step(1'b1, 7'd2, 128'h22, 1'b1, 3'd3, 1'b0, 1'b0, 7'd3);
      else if (c == 3) step(1'b1, 7'd3, 128'h33, 1'b1, 3'd3, 1'b1, 1'b0, 7'd3);
      else             idle(7'd3);
      check($sformatf("flush_pend_c%0d", c), pending_hit, 1'b0);
      check($sformatf("flush_rfwr_c%0d", c), rf_wr_en, (c == 7) || (c == 8));
      if (c == 7) check("flush_rf_addr_1", rf_addr, 7'd1);
      if (c == 8) check("flush_rf_addr_2", rf_addr, 7'd2);
    end

    // Latency encodings 0 and 1 behave as 2.
    for (int l = 0; l < 2; l++) begin
      do_reset();
      step(1'b1, 7'd4, 128'h44, 1'b1, 3'(l), 1'b0, 1'b0, 7'd4);
      check($sformatf("lat%0d_ready_c1", l), fwd_ready, '0);
      check($sformatf("lat%0d_pend_c1", l), pending_hit, 1'b1);
      idle(7'd4);
      check($sformatf("lat%0d_ready1_c2", l), fwd_ready[1], 1'b1);
      check($sformatf("lat%0d_pend_c2", l), pending_hit, 1'b0);
    end

    // Reset with three entries in flight.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 7'(10 + i), 128'(32'hA0 + i), 1'b1, 3'd3, 1'b0, 1'b0, 7'd11);
    step(1'b1, 7'd13, 128'hFF, 1'b1, 3'd3, 1'b0, 1'b1, 7'd11);
    check("rst_fwd_valid", fwd_valid, '0);
    check("rst_fwd_ready", fwd_ready, '0);
    check("rst_fwd_addr", 128'(fwd_addr), 128'd0);
    check("rst_fwd_data_s1", fwd_data[0 +: 128], 128'd0);
    check("rst_rf", {rf_wr_en, rf_addr, rf_data[0:63]}, '0);
    check("rst_pending", pending_hit, 1'b0);
    for (int c = 0; c < 9; c++) begin
      idle(7'd11);
      check("rst_no_writeback", rf_wr_en, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)),
           {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0,
           7'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/odd_result_pipe.md
# odd_result_pipe

Result-staging pipeline directly downstream of the SPU odd pipe (permute, shift/rotate, load/store, branch). Each cycle it accepts one odd-pipe result with its target register address and unit latency, carries it through a fixed-depth shift register, and exposes every stage to the forwarding network. A result is marked forwardable only once its unit latency has elapsed. At the last stage the pipe drives the register-file odd write port, and it exposes a pending-write lookup for the issue stage's RAW-stall logic.

## Interface
- DEPTH, 7, number of stages; writeback occurs from stage DEPTH
- DATA_W, 128, result width
- ADDR_W, 7, register address width
- FLUSH_DEPTH, 1, number of youngest stages (1..FLUSH_DEPTH) killed by flush
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  odd-pipe result valid this cycle
- in_data  in  [0:127]  result value (rt_wt_odd)
- in_addr  in  [0:6]  target register (addr_rt_wt_odd)
- in_wr_en  in  1  result writes the register file (regWr_en_odd); 0 for stores and non-link branches
- in_latency  in  [0:2]  unit latency in cycles, 2..7
- flush  in  1  branch redirect; kills younger results
- query_addr  in  [0:6]  issue-stage source register lookup
- fwd_valid  out  [0:DEPTH-1]  bit k-1: stage k holds valid, writing entry
- fwd_ready  out  [0:DEPTH-1]  bit k-1: stage k data is forwardable
- fwd_addr  out  [0:DEPTH*7-1]  stage k at [(k-1)*7 +: 7]
- fwd_data  out  [0:DEPTH*128-1]  stage k at [(k-1)*128 +: 128]
- rf_wr_en  out  1  register-file write enable
- rf_addr  out  [0:6]  register-file write address
- rf_data  out  [0:127]  register-file write data
- pending_hit  out  1  query_addr matches a valid, writing, not-yet-ready entry

## Operation
- Stage k holds {valid, wr_en, ready, lat, addr, data}.
- Stage 1 loads from the inputs. Stage k loads from stage k-1.
- Effective latency: lat_eff = max(in_latency, 2). Encodings 0 and 1 are treated as 2.
- ready in stage k = valid & (k >= lat). Recomputed per stage; it is not a sticky bit.
- An entry with in_wr_en=0 still advances through the pipe. fwd_valid, pending_hit and rf_wr_en ignore it.
- fwd_valid[k-1] = valid_k & wr_en_k.
- fwd_ready[k-1] = fwd_valid[k-1] & ready_k.
- rf_wr_en = valid_DEPTH & wr_en_DEPTH. rf_addr and rf_data come straight from stage DEPTH.
- pending_hit is combinational. It is the OR over k of (valid_k & wr_en_k & ~ready_k & addr_k == query_addr).
- If several stages write the same address, the forwarding consumer selects the lowest k with fwd_ready set (youngest). This block does not prioritise.
- Flush on the sampling edge:
  - the stage-1 load is suppressed (valid_1 <= 0);
  - valid is cleared in stages 2..FLUSH_DEPTH after shifting;
  - older stages advance normally, so a resolved branch-and-set-link still writes back.
- Data registers shift unconditionally. Only the valid bits are gated. No stall input exists; the pipe always advances.

## Timing
- Input sampled at edge T appears in stage 1 after T and in stage k after edge T+k-1.
- rf_wr_en is asserted in the cycle after edge T+DEPTH-1, i.e. DEPTH cycles after issue, and lasts 1 cycle.
- fwd_ready for a latency-L result first rises in the cycle after edge T+L-1.
- pending_hit for that result is high for L-1 cycles, then falls.
- Back-to-back inputs are accepted every cycle. There is no bubble and no back-pressure.
- Reset (synchronous) clears all valid bits and zeroes every stage's addr and data. Outputs then read:
  - fwd_valid = 0, fwd_ready = 0, fwd_addr = 0, fwd_data = 0;
  - rf_wr_en = 0, rf_addr = 0, rf_data = 0;
  - pending_hit = 0.
- Reset mid-flight discards all entries. No writeback occurs after the reset edge.
- Reset has priority over flush and in_valid.
- flush and in_valid in the same cycle: the input is dropped.

## Test plan
- Latency 4 result: in_addr=5, in_data=128'h0123…CDEF, in_wr_en=1 at edge 0.
  - pending_hit (query 5) high for cycles 1-3;
  - fwd_ready[3] high in cycle 4;
  - rf_wr_en=1, rf_addr=5, rf_data matches input in cycle 7 only.
- Store entry: in_wr_en=0, latency 6 → fwd_valid stays 0, pending_hit stays 0, rf_wr_en never rises.
- Back-to-back: addr 3 latency 2, then addr 3 latency 7 on consecutive edges.
  - rf_wr_en occurs in cycles 7 and 8 with the respective data;
  - pending_hit (query 3) is high from cycle 2 through cycle 7.
- Flush: inputs at edges 0,1,2 (addr 1,2,3); flush asserted with the edge-2 input.
  - addr 3 never appears;
  - with FLUSH_DEPTH=1, addr 1 and 2 write back in cycles 7 and 8.
- Latency encodings 0 and 1 → behave identically to 2 (fwd_ready[1] first high).
- Reset asserted in cycle 3 with 3 entries in flight → all outputs 0 the next cycle, and no rf_wr_en afterwards.
